sync_timing_counter: RTL and testbench

- Timing-count source feeding the sync/blanking state controller.
- Consumes that controller's counter-control outputs: cclr, pclr, pc, csm.
- Returns the terminal-count decode strobes it samples: cnt*, pcnt*.
- Holds a dot/half-line counter and a line counter; all decodes are single-cycle equality strobes.

---
 rtl/sync_timing_counter.sv | 122 ++++++++++++
 tb/tb_sync_timing_counter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sync_timing_counter.sv
// Dot and line timing counters with terminal-count equality strobes for the sync/blanking controller.
// Optional macro SYNC_TC_REG_EN registers every strobe from the counters' next-state values.
module sync_timing_counter #(
  parameter int CNT_W  = 10,
  parameter int PCNT_W = 8
) (
  input  logic              CK,
  input  logic              rst_n,
  input  logic              cclr,
  input  logic              csm,
  input  logic              pclr,
  input  logic              pc,
  output logic              cnt10,
  output logic              cnt13,
  output logic              cnt21,
  output logic              cnt44,
  output logic              cnt45,
  output logic              cnt261,
  output logic              cnt272,
  output logic              cnt283,
  output logic              cnt284,
  output logic              cnt509,
  output logic              cnt511,
  output logic              cnt567,
  output logic              cnt591,
  output logic              pcnt6,
  output logic              pcnt12,
  output logic              pcnt17,
  output logic              pcnt27,
  output logic              pcnt241,
  output logic [CNT_W-1:0]  cnt_q,
  output logic [PCNT_W-1:0] pcnt_q,
  output logic              povf
);

  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [PCNT_W-1:0] pcnt_nxt_s;
  logic              povf_nxt_s;
  logic [12:0]       cnt_dec_s;
  logic [4:0]        pcnt_dec_s;

  function automatic logic [12:0] cnt_decode(input logic [CNT_W-1:0] v);
    cnt_decode = {v == CNT_W'(10),  v == CNT_W'(13),  v == CNT_W'(21),
                  v == CNT_W'(44),  v == CNT_W'(45),  v == CNT_W'(261),
                  v == CNT_W'(272), v == CNT_W'(283), v == CNT_W'(284),
                  v == CNT_W'(509), v == CNT_W'(511), v == CNT_W'(567),
                  v == CNT_W'(591)};
  endfunction

  function automatic logic [4:0] pcnt_decode(input logic [PCNT_W-1:0] v);
    pcnt_decode = {v == PCNT_W'(6),  v == PCNT_W'(12), v == PCNT_W'(17),
                   v == PCNT_W'(27), v == PCNT_W'(241)};
  endfunction

  // Next-state priority: clear beats hold/advance on each counter.
  always_comb begin
    cnt_nxt_s  = cnt_q;
    pcnt_nxt_s = pcnt_q;
    povf_nxt_s = povf;
    if (cclr) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (csm) begin
      cnt_nxt_s = cnt_q;
    end else begin
      cnt_nxt_s = cnt_q + CNT_W'(1);
    end
    if (pclr) begin
      pcnt_nxt_s = {PCNT_W{1'b0}};
      povf_nxt_s = 1'b0;
    end else if (pc) begin
      pcnt_nxt_s = pcnt_q + PCNT_W'(1);
      if (pcnt_q == {PCNT_W{1'b1}}) begin
        povf_nxt_s = 1'b1;
      end else begin
        povf_nxt_s = povf;
      end
    end else begin
      pcnt_nxt_s = pcnt_q;
      povf_nxt_s = povf;
    end
  end

  // Counter and overflow registers with synchronous reset.
  always_ff @(posedge CK) begin
    if (!rst_n) begin
      cnt_q  <= {CNT_W{1'b0}};
      pcnt_q <= {PCNT_W{1'b0}};
      povf   <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt_s;
      pcnt_q <= pcnt_nxt_s;
      povf   <= povf_nxt_s;
    end
  end

`ifdef SYNC_TC_REG_EN
  logic [12:0] cnt_dec_r;
  logic [4:0]  pcnt_dec_r;

  // Strobe flops preload the compare of the next count so timing matches the combinational build.
  always_ff @(posedge CK) begin
    if (!rst_n) begin
      cnt_dec_r  <= 13'd0;
      pcnt_dec_r <= 5'd0;
    end else begin
      cnt_dec_r  <= cnt_decode(cnt_nxt_s);
      pcnt_dec_r <= pcnt_decode(pcnt_nxt_s);
    end
  end

  assign cnt_dec_s  = cnt_dec_r;
  assign pcnt_dec_s = pcnt_dec_r;
`else
  assign cnt_dec_s  = cnt_decode(cnt_q);
  assign pcnt_dec_s = pcnt_decode(pcnt_q);
`endif

  assign {cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272,
          cnt283, cnt284, cnt509, cnt511, cnt567, cnt591} = cnt_dec_s;
  assign {pcnt6, pcnt12, pcnt17, pcnt27, pcnt241} = pcnt_dec_s;

endmodule

// File: tb/tb_sync_timing_counter.sv
// Directed plus randomized bench for sync_timing_counter against an arithmetic reference model.
module tb_sync_timing_counter;

  localparam int CNT_W  = 10;
  localparam int PCNT_W = 8;
  localparam int CMOD   = 1 << CNT_W;
  localparam int PMOD   = 1 << PCNT_W;

  logic CK = 1'b0;
  logic rst_n = 1'b0, cclr = 1'b0, csm = 1'b0, pclr = 1'b0, pc = 1'b0;
  logic cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283, cnt284;
  logic cnt509, cnt511, cnt567, cnt591;
  logic pcnt6, pcnt12, pcnt17, pcnt27, pcnt241;
  logic [CNT_W-1:0]  cnt_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic povf;

  int total = 0;
  int bad   = 0;
  int m_cnt = 0, m_pcnt = 0, m_povf = 0;
  int cnt_k[13]  = '{10, 13, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591};
  int pcnt_k[5]  = '{6, 12, 17, 27, 241};

  sync_timing_counter #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
    .CK(CK), .rst_n(rst_n), .cclr(cclr), .csm(csm), .pclr(pclr), .pc(pc),
    .cnt10(cnt10), .cnt13(cnt13), .cnt21(cnt21), .cnt44(cnt44), .cnt45(cnt45),
    .cnt261(cnt261), .cnt272(cnt272), .cnt283(cnt283), .cnt284(cnt284),
    .cnt509(cnt509), .cnt511(cnt511), .cnt567(cnt567), .cnt591(cnt591),
    .pcnt6(pcnt6), .pcnt12(pcnt12), .pcnt17(pcnt17), .pcnt27(pcnt27), .pcnt241(pcnt241),
    .cnt_q(cnt_q), .pcnt_q(pcnt_q), .povf(povf)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] dut_cnt_vec();
    return {cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272,
            cnt283, cnt284, cnt509, cnt511, cnt567, cnt591};
  endfunction

  function automatic logic [4:0] dut_pcnt_vec();
    return {pcnt6, pcnt12, pcnt17, pcnt27, pcnt241};
  endfunction

  // Compare every output against the model state.
  task automatic check_all(input string tag);
    logic [12:0] ec;
    logic [4:0]  ep;
    for (int i = 0; i < 13; i++) ec[12-i] = (m_cnt == cnt_k[i]);
    for (int i = 0; i < 5; i++)  ep[4-i]  = (m_pcnt == pcnt_k[i]);
    chk({tag, ".cnt_q"},  32'(cnt_q),  32'(m_cnt));
    chk({tag, ".pcnt_q"}, 32'(pcnt_q), 32'(m_pcnt));
    chk({tag, ".povf"},   32'(povf),   32'(m_povf));
    chk({tag, ".cnt_strobes"},  32'(dut_cnt_vec()),  32'(ec));
    chk({tag, ".pcnt_strobes"}, 32'(dut_pcnt_vec()), 32'(ep));
  endtask

  // One clock: drive inputs, advance the model by the rules, sample #1 after the edge.
  task automatic step(input logic r, input logic cc, input logic cs,
                      input logic pl, input logic p, input string tag);
    rst_n = r; cclr = cc; csm = cs; pclr = pl; pc = p;
    @(posedge CK);
    if (!r) begin
      m_cnt = 0; m_pcnt = 0; m_povf = 0;
    end else begin
      if (cc) m_cnt = 0;
      else if (!cs) m_cnt = (m_cnt + 1) % CMOD;
      if (pl) begin
        m_pcnt = 0; m_povf = 0;
      end else if (p) begin
        if (m_pcnt == PMOD - 1) m_povf = 1;
        m_pcnt = (m_pcnt + 1) % PMOD;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int first10, n10, n591, n44, n45, n241;

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");

    // Free run through one wrap
    first10 = -1; n10 = 0; n591 = 0;
    for (int k = 1; k <= 1040; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "freerun");
      if (cnt10) begin
        n10++;
        if (first10 < 0) first10 = k;
      end
      if (cnt591) n591++;
      if (k == 1034) chk("cnt10_after_wrap", 32'(cnt10), 32'd1);
    end
    chk("cnt10_first_cycle", 32'(first10), 32'd10);
    chk("cnt10_count", 32'(n10), 32'd2);
    chk("cnt591_count", 32'(n591), 32'd1);

    // Hold on 44
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "clr44");
    for (int k = 0; k < 44; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "to44");
    n44 = cnt44 ? 1 : 0; n45 = cnt45 ? 1 : 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "hold44");
      if (cnt44) n44++;
      if (cnt45) n45++;
    end
    chk("cnt44_held_cycles", 32'(n44), 32'd6);
    chk("cnt45_during_hold", 32'(n45), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "release44");
    chk("cnt45_after_release", 32'(cnt45), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "past45");
    chk("cnt45_one_cycle", 32'(cnt45), 32'd0);

    // cclr beats csm at 300
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "clr300");
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "to300");
    chk("cnt_at_300", 32'(cnt_q), 32'd300);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "cclr_csm");
    chk("cclr_beats_csm", 32'(cnt_q), 32'd0);
    for (int k = 0; k < 13; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "to13");
    chk("cnt13_after_clear", 32'(cnt13), 32'd1);

    // 17 pc pulses
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "pclr");
    for (int k = 0; k < 17; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "pc_pulse");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pc_gap");
    end
    chk("pcnt17_after_pulses", 32'(pcnt17), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "pclr_pc");
    chk("pclr_beats_pc", 32'(pcnt_q), 32'd0);
    chk("pcnt17_cleared", 32'(pcnt17), 32'd0);

    // pc held 256 cycles -> wrap and overflow
    n241 = 0;
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "pc_run");
      if (pcnt241) n241++;
    end
    chk("pcnt_wrapped", 32'(pcnt_q), 32'd0);
    chk("povf_set", 32'(povf), 32'd1);
    chk("pcnt241_once", 32'(n241), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "pclr_ovf");
    chk("povf_cleared", 32'(povf), 32'd0);

    // Reset at cnt 509 / pcnt 241
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "clr_both");
    for (int k = 0; k < 241; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "to241");
    for (int k = 0; k < 268; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "to509");
    chk("cnt509_before_rst", 32'(cnt509), 32'd1);
    chk("pcnt241_before_rst", 32'(pcnt241), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("no_async_reset_cnt", 32'(cnt_q), 32'd509);
    chk("no_async_reset_pcnt", 32'(pcnt_q), 32'd241);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid_reset");
    chk("reset_cnt_zero", 32'(cnt_q), 32'd0);
    chk("reset_strobes_zero", 32'({dut_cnt_vec(), dut_pcnt_vec()}), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(63) != 0), ($urandom_range(15) == 0), ($urandom_range(3) == 0),
           ($urandom_range(31) == 0), ($urandom_range(1) == 1), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
